// File: rtl/bias_ctrl_pkg.sv
// rtl/bias_ctrl_pkg.sv - shared constants and FSM state type for the bias fetch controller
package bias_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int LANES  = 6;
  localparam int BIAS_W = 18;
  localparam int CNT_W  = 10;
  localparam int WORD_W = LANES * BIAS_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bias_skid_fifo.sv
// rtl/bias_skid_fifo.sv - 2-entry FIFO carrying {last, data} between bias RAM and accumulator
module bias_skid_fifo
  import bias_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [WORD_W:0] push_data,
  input  logic            pop,
  output logic [WORD_W:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic [1:0]      occupancy
);

  logic [WORD_W:0] mem0_q, mem0_d;
  logic [WORD_W:0] mem1_q, mem1_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      occ_q, occ_d;
  logic            push_ok;
  logic            pop_ok;

  assign full      = (occ_q == 2'd2);
  assign empty     = (occ_q == 2'd0);
  assign occupancy = occ_q;
  assign pop_data  = rd_ptr_q ? mem1_q : mem0_q;

  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      if (wr_ptr_q) mem1_d = push_data;
      else          mem0_d = push_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // storage and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/bias_fetch_ctrl.sv
// rtl/bias_fetch_ctrl.sv - fetches a run of bias RAM words and streams them to the accumulator
module bias_fetch_ctrl
  import bias_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_groups,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic [WORD_W-1:0] bias_data,
  output logic              bias_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              err_q, err_d;

  logic              issue;
  logic              pop;
  logic              last_issue;
  logic [2:0]        room_sum;
  logic [WORD_W:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_occ;

  assign bias_valid = !fifo_empty;
  assign bias_data  = fifo_head[WORD_W-1:0];
  assign bias_last  = !fifo_empty && fifo_head[WORD_W];
  assign pop        = bias_valid && bias_ready;
  assign ram_addr   = ram_addr_q;
  assign err        = err_q;
  assign last_issue = (remaining_q == CNT_W'(1));

  // slots committed after this cycle: stored words plus the read returning now, minus the word leaving
  assign room_sum = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (num_groups != '0)) state_d = FETCH;
      FETCH:   if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && fifo_head[WORD_W]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the full-without-pop guard is redundant with room_sum but keeps the FIFO safe on its own
  always_comb begin
    busy  = (state_q == FETCH) || (state_q == DRAIN);
    done  = (state_q == DONE);
    issue = (state_q == FETCH) && (room_sum < 3'd2) && !(fifo_full && !pop);
  end

  // address, count and read-pipeline next values; the address is pre-advanced so it is ready for the next issue
  always_comb begin
    ram_addr_d      = ram_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && last_issue;
    err_d           = 1'b0;
    if ((state_q == IDLE) && start) begin
      if (num_groups != '0) begin
        ram_addr_d  = base_addr;
        remaining_d = num_groups;
      end else begin
        err_d = 1'b1;
      end
    end
    if (issue) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (!last_issue) ram_addr_d = ram_addr_q + ADDR_W'(1);
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      ram_addr_q      <= ram_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      err_q           <= err_d;
    end
  end

  bias_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_rdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// tb/tb_bias_fetch_ctrl.sv - self-checking bench for bias_fetch_ctrl
module tb_bias_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [8:0]   base_addr = '0;
  logic [9:0]   num_groups = '0;
  logic         busy, done, err;
  logic [8:0]   ram_addr;
  logic [107:0] ram_rdata = '0;
  logic         bias_valid;
  logic         bias_ready = 1'b1;
  logic [107:0] bias_data;
  logic         bias_last;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic       start;
    logic [8:0] base;
    logic [9:0] num;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       valid;
    logic       last;
    logic [8:0] addr;
    logic [8:0] daddr;
  } vec_t;

  vec_t tbl [25];

  bias_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_groups (num_groups),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready),
    .bias_data  (bias_data),
    .bias_last  (bias_last)
  );

  always #5 clk = ~clk;

  function automatic logic [107:0] word_of(input logic [8:0] a);
    logic [107:0] w;
    logic [2:0]   li;
    logic [5:0]   mix;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      li  = 3'(i);
      mix = a[5:0] ^ 6'(i * 7);
      w[18*i +: 18] = {a, li, mix};
    end
    return w;
  endfunction

  // synchronous-read bias RAM model, one cycle latency
  always @(posedge clk) ram_rdata <= word_of(ram_addr);

  function automatic vec_t mk(input logic st, input logic [8:0] b, input logic [9:0] n,
                              input logic rdy, input logic bz, input logic dn, input logic er,
                              input logic vl, input logic ls, input logic [8:0] ad,
                              input logic [8:0] da);
    vec_t v;
    v.start = st; v.base = b; v.num = n; v.ready = rdy;
    v.busy = bz; v.done = dn; v.err = er; v.valid = vl; v.last = ls;
    v.addr = ad; v.daddr = da;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk); #1;
      start      = tbl[i].start;
      base_addr  = tbl[i].base;
      num_groups = tbl[i].num;
      bias_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("row%0d busy", i),  108'(busy),       108'(tbl[i].busy));
      chk($sformatf("row%0d done", i),  108'(done),       108'(tbl[i].done));
      chk($sformatf("row%0d err", i),   108'(err),        108'(tbl[i].err));
      chk($sformatf("row%0d valid", i), 108'(bias_valid), 108'(tbl[i].valid));
      chk($sformatf("row%0d last", i),  108'(bias_last),  108'(tbl[i].last));
      chk($sformatf("row%0d addr", i),  108'(ram_addr),   108'(tbl[i].addr));
      if (tbl[i].valid) chk($sformatf("row%0d data", i), bias_data, word_of(tbl[i].daddr));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_stream(input string nm, input logic [8:0] base, input logic [9:0] n,
                            input bit toggle);
    int beats = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    int max_occ = 0;
    bit stalled = 1'b0;
    logic [107:0] hd = '0;
    logic hl = 1'b0;
    logic [8:0] ea;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      start      = (k == 0);
      base_addr  = base;
      num_groups = n;
      bias_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (int'(dut.u_fifo.occupancy) > max_occ) max_occ = int'(dut.u_fifo.occupancy);
      if (stalled) begin
        chk({nm, " hold_valid"}, 108'(bias_valid), 108'(1));
        chk({nm, " hold_data"}, bias_data, hd);
        chk({nm, " hold_last"}, 108'(bias_last), 108'(hl));
      end
      if (bias_valid && bias_ready) begin
        ea = base + 9'(beats);
        chk($sformatf("%s beat%0d data", nm, beats), bias_data, word_of(ea));
        chk($sformatf("%s beat%0d last", nm, beats), 108'(bias_last),
            108'(beats == int'(n) - 1));
        beats++;
        if (beats == int'(n)) last_cyc = k;
      end
      if (done) done_cyc = k;
      stalled = bias_valid && !bias_ready;
      hd = bias_data;
      hl = bias_last;
    end
    chk({nm, " beats"}, 108'(beats), 108'(n));
    chk({nm, " done_seen"}, 108'(done_cyc >= 0), 108'(1));
    chk({nm, " done_lat"}, 108'(done_cyc - last_cyc), 108'(1));
    chk({nm, " occ_le2"}, 108'(max_occ > 2), 108'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;

    // base 0, four words, ready high
    tbl[0]  = mk(1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 2, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 3, 1);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 3, 2);
    tbl[6]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 3, 3);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 3, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    // zero-length start: err pulse, address untouched
    tbl[9]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    // two-word run with an ignored start mid-run
    tbl[12] = mk(1, 20, 2, 1, 0, 0, 0, 0, 0, 3, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 20, 0);
    tbl[14] = mk(1, 100, 5, 1, 1, 0, 0, 0, 0, 21, 0);
    tbl[15] = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 21, 20);
    tbl[16] = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 21, 21);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 21, 0);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 21, 0);
    // single-word run at base 7
    tbl[19] = mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 21, 0);
    tbl[20] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 7, 0);
    tbl[21] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 7, 0);
    tbl[22] = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 7, 7);
    tbl[23] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 7, 0);
    tbl[24] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",  108'(busy),       108'(0));
    chk("rst done",  108'(done),       108'(0));
    chk("rst err",   108'(err),        108'(0));
    chk("rst addr",  108'(ram_addr),   108'(0));
    chk("rst valid", 108'(bias_valid), 108'(0));
    chk("rst data",  bias_data,        108'(0));
    chk("rst last",  108'(bias_last),  108'(0));
    rst = 1'b0;

    run_rows(0, 24);

    run_stream("wrap", 9'd510, 10'd4, 1'b0);
    run_stream("stall", 9'd40, 10'd8, 1'b1);

    // fill the FIFO under backpressure, then reset asynchronously
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'd0; num_groups = 10'd8; bias_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst occ", 108'(dut.u_fifo.occupancy), 108'(2));
    #1;
    rst = 1'b1;
    #1;
    chk("arst busy",  108'(busy),       108'(0));
    chk("arst done",  108'(done),       108'(0));
    chk("arst err",   108'(err),        108'(0));
    chk("arst addr",  108'(ram_addr),   108'(0));
    chk("arst valid", 108'(bias_valid), 108'(0));
    chk("arst data",  bias_data,        108'(0));
    chk("arst last",  108'(bias_last),  108'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bias_ready = 1'b1;
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || bias_valid) done_seen = 1'b1;
    end
    chk("post_rst quiet", 108'(done_seen), 108'(0));

    run_rows(0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
